lift_sched: RTL and testbench

//  Lift car scheduler. Latches debounced floor-call buttons, picks the next floor with a

---
 rtl/lift_sched.sv | 184 ++++++++++++++++++
 tb/tb_lift_sched.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_sched.sv
// Lift car scheduler: latches floor calls, SCAN floor selection,
// motor/door control from a prescaled tick, and debouncer strobe.
module lift_sched #(
    parameter int NFLOORS      = 4,
    parameter int TICK_DIV     = 1562500,
    parameter int TRAVEL_TICKS = 32,
    parameter int DOOR_TICKS   = 64,
    localparam int FLW = (NFLOORS > 1) ? $clog2(NFLOORS) : 1
) (
    input  logic               clk,
    input  logic               resetb,
    input  logic [NFLOORS-1:0] call_n,
    output logic               slowref,
    output logic [FLW-1:0]     cur_floor,
    output logic               motor_up,
    output logic               motor_dn,
    output logic               door_open,
    output logic [NFLOORS-1:0] req_pend,
    output logic               busy
);

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS
                                                      : DOOR_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [PW-1:0]  PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0]  TRV_LAST  = TW'(TRAVEL_TICKS - 1);
    localparam logic [TW-1:0]  DOOR_LAST = TW'(DOOR_TICKS - 1);
    localparam logic [FLW-1:0] TOP       = FLW'(NFLOORS - 1);
    localparam logic [FLW-1:0] BOTTOM    = '0;

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DN,
        DOOR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PW-1:0]      pre;
    logic [PW-1:0]      pre_nxt;
    logic [TW-1:0]      timer;
    logic [TW-1:0]      timer_nxt;
    logic [FLW-1:0]     floor_nxt;
    logic               dir_up;
    logic               dir_nxt;
    logic [NFLOORS-1:0] hist;
    logic [NFLOORS-1:0] fall;
    logic [NFLOORS-1:0] set_mask;
    logic [NFLOORS-1:0] clr_mask;
    logic               tick;
    logic               restart;
    logic               above;
    logic               below;

    assign tick    = (pre == PRE_LAST);
    assign fall    = hist & ~call_n;
    assign restart = (state == DOOR) && fall[cur_floor];

    // Free-running prescaler wraps after the tick count.
    always_comb begin
        pre_nxt = tick ? '0 : pre + 1'b1;
    end

    // A new call at the open door only restarts the door; no latch.
    always_comb begin
        set_mask = fall;
        if (restart) begin
            set_mask[cur_floor] = 1'b0;
        end
    end

    // Any pending request strictly above / below the car.
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NFLOORS; i++) begin
            if (req_pend[i]) begin
                if (i > int'(cur_floor)) above = 1'b1;
                if (i < int'(cur_floor)) below = 1'b1;
            end
        end
    end

    // SCAN next-state, travel/door timing and request clearing.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        floor_nxt = cur_floor;
        dir_nxt   = dir_up;
        clr_mask  = '0;
        unique case (state)
            IDLE: begin
                if (req_pend[cur_floor]) begin
                    state_nxt           = DOOR;
                    timer_nxt           = '0;
                    clr_mask[cur_floor] = 1'b1;
                end else if (above && (dir_up || !below)) begin
                    state_nxt = MOVE_UP;
                    dir_nxt   = 1'b1;
                    timer_nxt = '0;
                end else if (below) begin
                    state_nxt = MOVE_DN;
                    dir_nxt   = 1'b0;
                    timer_nxt = '0;
                end
            end
            MOVE_UP, MOVE_DN: begin
                if (tick) begin
                    if (timer == TRV_LAST) begin
                        timer_nxt = '0;
                        if (state == MOVE_UP) begin
                            if (cur_floor != TOP)
                                floor_nxt = cur_floor + 1'b1;
                        end else begin
                            if (cur_floor != BOTTOM)
                                floor_nxt = cur_floor - 1'b1;
                        end
                        if (req_pend[floor_nxt] || floor_nxt == TOP ||
                            floor_nxt == BOTTOM) begin
                            state_nxt           = DOOR;
                            clr_mask[floor_nxt] = 1'b1;
                        end
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
            end
            DOOR: begin
                if (restart) begin
                    timer_nxt = '0;
                end else if (tick) begin
                    if (timer == DOOR_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Timebase strobe, call edge history and request latch.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            pre      <= '0;
            slowref  <= 1'b0;
            hist     <= '1;
            req_pend <= '0;
        end else begin
            pre      <= pre_nxt;
            slowref  <= (pre_nxt == PRE_LAST);
            hist     <= call_n;
            req_pend <= (req_pend | set_mask) & ~clr_mask;
        end
    end

    // State register and registered output decodes.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state     <= IDLE;
            timer     <= '0;
            cur_floor <= '0;
            dir_up    <= 1'b1;
            motor_up  <= 1'b0;
            motor_dn  <= 1'b0;
            door_open <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            timer     <= timer_nxt;
            cur_floor <= floor_nxt;
            dir_up    <= dir_nxt;
            motor_up  <= (state_nxt == MOVE_UP);
            motor_dn  <= (state_nxt == MOVE_DN);
            door_open <= (state_nxt == DOOR);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_lift_sched.sv
// Bench for lift_sched: directed scenarios plus random calls,
// all compared against a countdown-based reference model.
module tb_lift_sched;

    localparam int NF = 4;
    localparam int TD = 4;
    localparam int TR = 2;
    localparam int DR = 3;

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic [NF-1:0] call_n = '1;
    logic          slowref;
    logic [1:0]    cur_floor;
    logic          motor_up;
    logic          motor_dn;
    logic          door_open;
    logic [NF-1:0] req_pend;
    logic          busy;
    logic [10:0]   dv;

    int n_cmp = 0;
    int n_bad = 0;

    lift_sched #(
        .NFLOORS(NF),
        .TICK_DIV(TD),
        .TRAVEL_TICKS(TR),
        .DOOR_TICKS(DR)
    ) dut (
        .clk(clk),
        .resetb(resetb),
        .call_n(call_n),
        .slowref(slowref),
        .cur_floor(cur_floor),
        .motor_up(motor_up),
        .motor_dn(motor_dn),
        .door_open(door_open),
        .req_pend(req_pend),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign dv = {slowref, cur_floor, motor_up, motor_dn,
                 door_open, req_pend, busy};

    // Reference model: mode 0 idle, 1 up, 2 down, 3 door.
    // m_left counts remaining ticks of the current leg or door hold.
    int            m_pre = 0;
    int            m_floor = 0;
    int            m_mode = 0;
    int            m_left = 0;
    bit            m_slow = 0;
    bit            m_up = 1;
    logic [NF-1:0] m_pend = '0;
    logic [NF-1:0] m_hist = '1;

    always @(posedge clk) begin : ref_model
        logic [NF-1:0] fall;
        logic [NF-1:0] clr;
        bit tk;
        bit rst;
        bit ab;
        bit be;
        if (!resetb) begin
            m_pre = 0; m_slow = 0; m_floor = 0; m_up = 1;
            m_mode = 0; m_left = 0; m_pend = '0; m_hist = '1;
        end else begin
            tk = (m_pre == TD - 1);
            m_pre = (m_pre + 1) % TD;
            m_slow = (m_pre == TD - 1);
            fall = m_hist & ~call_n;
            m_hist = call_n;
            clr = '0;
            rst = (m_mode == 3) && fall[m_floor];
            if (rst) fall[m_floor] = 1'b0;
            ab = 0;
            be = 0;
            for (int i = 0; i < NF; i++) begin
                if (m_pend[i] && i > m_floor) ab = 1;
                if (m_pend[i] && i < m_floor) be = 1;
            end
            case (m_mode)
                0: begin
                    if (m_pend[m_floor]) begin
                        m_mode = 3; m_left = DR; clr[m_floor] = 1'b1;
                    end else if (ab && (m_up || !be)) begin
                        m_mode = 1; m_up = 1; m_left = TR;
                    end else if (be) begin
                        m_mode = 2; m_up = 0; m_left = TR;
                    end
                end
                1, 2: begin
                    if (tk) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_floor += (m_mode == 1) ? 1 : -1;
                            if (m_pend[m_floor] || m_floor == 0 ||
                                m_floor == NF - 1) begin
                                m_mode = 3; m_left = DR;
                                clr[m_floor] = 1'b1;
                            end else begin
                                m_left = TR;
                            end
                        end
                    end
                end
                default: begin
                    if (rst) begin
                        m_left = DR;
                    end else if (tk) begin
                        m_left--;
                        if (m_left == 0) m_mode = 0;
                    end
                end
            endcase
            m_pend = (m_pend | fall) & ~clr;
        end
    end

    function automatic logic [10:0] exp_vec();
        logic [1:0] f;
        f = m_floor[1:0];
        return {m_slow, f, m_mode == 1, m_mode == 2,
                m_mode == 3, m_pend, m_mode != 0};
    endfunction

    task automatic test_reset();
        resetb = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (dv !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_out: got %b expected %b", dv, 11'b0);
        end
        resetb = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if (slowref !== ((k % TD) == TD - 1)) begin
                n_bad++;
                $display("FAIL slowref k=%0d: got %b expected %b",
                         k, slowref, (k % TD) == TD - 1);
            end
            n_cmp++;
            if (dv !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_idle: got %b expected %b",
                         dv, exp_vec());
            end
        end
    endtask

    task automatic test_door_here();
        int ticks;
        bit done;
        ticks = 0;
        done = 0;
        call_n[0] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({req_pend, door_open} !== 5'b0001_0) begin
            n_bad++;
            $display("FAIL latch0: got %b expected %b",
                     {req_pend, door_open}, 5'b0001_0);
        end
        call_n[0] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({req_pend, door_open} !== 5'b0000_1) begin
            n_bad++;
            $display("FAIL door0: got %b expected %b",
                     {req_pend, door_open}, 5'b0000_1);
        end
        for (int k = 0; k < 100 && !done; k++) begin
            n_cmp++;
            if (dv !== exp_vec()) begin
                n_bad++;
                $display("FAIL door0_seq: got %b expected %b",
                         dv, exp_vec());
            end
            if (!door_open) done = 1;
            else if (slowref) ticks++;
            if (!done) @(negedge clk);
        end
        n_cmp++;
        if (!done || ticks != DR || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL door0_hold: got ticks %0d busy %b expected %0d 0",
                     ticks, busy, DR);
        end
    endtask

    task automatic test_move_up();
        int ticks;
        bit seen1;
        bit done;
        ticks = 0;
        seen1 = 0;
        done = 0;
        call_n[2] = 1'b0;
        @(negedge clk);
        call_n[2] = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            n_cmp++;
            if (dv !== exp_vec()) begin
                n_bad++;
                $display("FAIL up_seq: got %b expected %b", dv, exp_vec());
            end
            if (cur_floor == 2'd1 && !seen1) begin
                seen1 = 1;
                n_cmp++;
                if (ticks != 2) begin
                    n_bad++;
                    $display("FAIL up_floor1: got %0d ticks expected 2", ticks);
                end
            end
            if (door_open) begin
                done = 1;
                n_cmp++;
                if (cur_floor !== 2'd2 || ticks != 4) begin
                    n_bad++;
                    $display("FAIL up_arrive: got floor %0d ticks %0d expected 2 4",
                             cur_floor, ticks);
                end
            end
            if (motor_up && slowref) ticks++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL up_timeout: got no door expected door at 2");
        end
    endtask

    task automatic test_scan();
        int doors[$];
        bit prev;
        bit seen_dn;
        bit at1;
        prev = 0;
        seen_dn = 0;
        at1 = 0;
        resetb = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        call_n[3] = 1'b0;
        @(negedge clk);
        call_n[3] = 1'b1;
        for (int k = 0; k < 200 && !at1; k++) begin
            @(negedge clk);
            n_cmp++;
            if (dv !== exp_vec()) begin
                n_bad++;
                $display("FAIL scan_up: got %b expected %b", dv, exp_vec());
            end
            if (cur_floor == 2'd1) at1 = 1;
        end
        call_n[0] = 1'b0;
        @(negedge clk);
        call_n[0] = 1'b1;
        for (int k = 0; k < 400 && doors.size() < 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if (dv !== exp_vec()) begin
                n_bad++;
                $display("FAIL scan_seq: got %b expected %b", dv, exp_vec());
            end
            if (door_open && !prev) doors.push_back(int'(cur_floor));
            prev = door_open;
            if (motor_dn && !seen_dn) begin
                seen_dn = 1;
                n_cmp++;
                if (cur_floor !== 2'd3) begin
                    n_bad++;
                    $display("FAIL scan_turn: got floor %0d expected 3",
                             cur_floor);
                end
            end
        end
        n_cmp++;
        if (doors.size() != 2 || doors[0] != 3 || doors[1] != 0) begin
            n_bad++;
            $display("FAIL scan_order: got %0d doors expected 3 then 0",
                     doors.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        ok = 0;
        for (int k = 0; k < 100 && busy; k++) @(negedge clk);
        call_n[2] = 1'b0;
        @(negedge clk);
        call_n[2] = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (motor_up && cur_floor == 2'd1) ok = 1;
        end
        n_cmp++;
        if (!ok || req_pend !== 4'b0100) begin
            n_bad++;
            $display("FAIL mid_setup: got req %b expected 0100", req_pend);
        end
        resetb = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dv !== 11'b0) begin
            n_bad++;
            $display("FAIL mid_reset: got %b expected %b", dv, 11'b0);
        end
        resetb = 1'b1;
    endtask

    task automatic test_door_call();
        int ticks;
        bit done;
        ticks = 0;
        done = 0;
        call_n[2] = 1'b0;
        @(negedge clk);
        call_n[2] = 1'b1;
        for (int k = 0; k < 200 && !(door_open && cur_floor == 2'd2); k++)
            @(negedge clk);
        repeat (2) @(negedge clk);
        call_n[2] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (req_pend[2] !== 1'b0 || door_open !== 1'b1) begin
            n_bad++;
            $display("FAIL dcall_latch: got req %b door %b expected 0 1",
                     req_pend[2], door_open);
        end
        for (int k = 0; k < 100 && !done; k++) begin
            n_cmp++;
            if (dv !== exp_vec()) begin
                n_bad++;
                $display("FAIL dcall_seq: got %b expected %b", dv, exp_vec());
            end
            if (!door_open) done = 1;
            else if (slowref) ticks++;
            if (!done) @(negedge clk);
        end
        n_cmp++;
        if (!done || ticks != DR) begin
            n_bad++;
            $display("FAIL dcall_hold: got %0d ticks expected %0d", ticks, DR);
        end
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            n_cmp++;
            if (req_pend !== 4'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL dcall_held: got req %b busy %b expected 0000 0",
                         req_pend, busy);
            end
        end
        call_n[2] = 1'b1;
    endtask

    task automatic test_random();
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            n_cmp++;
            if (dv !== exp_vec()) begin
                n_bad++;
                $display("FAIL rand k=%0d: got %b expected %b",
                         k, dv, exp_vec());
            end
            n_cmp++;
            if ((motor_up && motor_dn) ||
                ((motor_up || motor_dn) && door_open)) begin
                n_bad++;
                $display("FAIL rand_excl: got up %b dn %b door %b expected exclusive",
                         motor_up, motor_dn, door_open);
            end
            for (int i = 0; i < NF; i++)
                if ($urandom_range(0, 29) == 0) call_n[i] = ~call_n[i];
            resetb = ($urandom_range(0, 1999) != 0);
        end
        resetb = 1'b1;
    endtask

    initial begin
        test_reset();
        test_door_here();
        test_move_up();
        test_scan();
        test_reset_mid();
        test_door_call();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
